gauss3x3_stream: RTL and testbench

//  Streaming 3x3 Gaussian filter for the OV5640 capture path, parametrised in frame size and pixel width.

---
 rtl/gauss3x3_stream_if.sv | 25 ++
 rtl/gauss3x3_stream.sv | 177 +++++++++++++++++
 tb/tb_gauss3x3_stream.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gauss3x3_stream_if.sv
// Pixel stream bundle for the 3x3 filter: input handshake, output beat flags and status.
interface gauss3x3_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              frame_done;
    logic              busy;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, out_valid, out_data, out_sof, out_eol, frame_done, busy
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, out_valid, out_data, out_sof, out_eol, frame_done, busy
    );
endinterface

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian (or centre-tap bypass) filter with two line buffers and zeroed borders.
// Output k appears 2 clk after beat k+W+1; no output backpressure, in_ready drops only while flushing.
module gauss3x3_stream #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 8,
    parameter int MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    gauss3x3_stream_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam int SW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] in_col, out_col, addr;
    logic [RW-1:0] in_row, out_row;
    logic [FW-1:0] flush_cnt;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] t1, t2, m1, m2, b1, b2;
    logic [DATA_W-1:0] top_new, mid_new, pix;
    logic [SW-1:0]     sum_c;

    logic              s1_vld, s1_border, s1_sof, s1_eol, s1_last;
    logic [SW-1:0]     s1_sum;
    logic [DATA_W-1:0] s1_ctr;
    logic [SW-1:0]     rnd;
    logic [DATA_W-1:0] filt;

    logic xfer, start, restart, beat_in, flush_beat, beat, out_beat;
    logic fill_end, last_in, flush_end;

    assign xfer       = bus.in_valid & bus.in_ready;
    assign start      = xfer & bus.in_sof;
    assign restart    = start & ((state == FILL) | (state == RUN));
    assign beat_in    = xfer & (bus.in_sof | (state == FILL) | (state == RUN));
    assign flush_beat = (state == FLUSH);
    assign beat       = beat_in | flush_beat;
    assign out_beat   = (xfer & ~bus.in_sof & (state == RUN)) | flush_beat;
    assign fill_end   = xfer & ~bus.in_sof & (state == FILL) & (in_row == RW'(1)) & (in_col == '0);
    assign last_in    = xfer & ~bus.in_sof & (state == RUN) & (in_row == ROW_LAST) & (in_col == COL_LAST);
    assign flush_end  = flush_beat & (flush_cnt == FLUSH_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (fill_end)  state_nxt = RUN;
                RUN:     if (last_in)   state_nxt = FLUSH;
                FLUSH:   if (flush_end) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state != FLUSH);
        bus.busy     = (state != IDLE);
    end

    // A start pixel is always column 0, whatever the counters held.
    assign addr    = start ? '0 : in_col;
    assign pix     = flush_beat ? '0 : bus.in_data;
    assign top_new = lb0[addr];
    assign mid_new = lb1[addr];

    always_ff @(posedge clk) begin
        if (beat_in) begin
            lb1[addr] <= pix;
            lb0[addr] <= mid_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            flush_cnt <= '0;
        end else begin
            if (start) begin
                in_col <= CW'(1);
                in_row <= '0;
            end else if (beat_in) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end
            if (last_in)         flush_cnt <= '0;
            else if (flush_beat) flush_cnt <= flush_cnt + FW'(1);
            if (start) begin
                out_col <= '0;
                out_row <= '0;
            end else if (out_beat) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {t1, t2, m1, m2, b1, b2} <= '0;
        end else if (beat) begin
            t2 <= t1;  t1 <= top_new;
            m2 <= m1;  m1 <= mid_new;
            b2 <= b1;  b1 <= pix;
        end
    end

    // Window centre is m1: the new column is col c, the register taps are c-1 and c-2.
    assign sum_c = SW'(top_new) + SW'(t2) + SW'(pix) + SW'(b2)
                 + ((SW'(t1) + SW'(mid_new) + SW'(m2) + SW'(b1)) << 1)
                 + (SW'(m1) << 2);

    assign rnd  = (s1_sum + SW'(8)) >> 4;
    assign filt = (|rnd[SW-1:DATA_W]) ? '1 : rnd[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld         <= 1'b0;
            s1_sum         <= '0;
            s1_ctr         <= '0;
            s1_border      <= 1'b0;
            s1_sof         <= 1'b0;
            s1_eol         <= 1'b0;
            s1_last        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_sof    <= 1'b0;
            bus.out_eol    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            s1_vld    <= out_beat;
            s1_sum    <= sum_c;
            s1_ctr    <= m1;
            s1_border <= (out_row == '0) | (out_row == ROW_LAST) | (out_col == '0) | (out_col == COL_LAST);
            s1_sof    <= (out_row == '0) & (out_col == '0);
            s1_eol    <= (out_col == COL_LAST);
            s1_last   <= flush_end;
            // A restart kills whatever is still in flight, including a pending frame_done.
            bus.out_valid  <= s1_vld & ~restart;
            bus.out_sof    <= s1_vld & ~restart & s1_sof;
            bus.out_eol    <= s1_vld & ~restart & s1_eol;
            bus.frame_done <= s1_vld & ~restart & s1_last;
            if (s1_vld & ~restart & ~s1_border)
                bus.out_data <= (MODE == 1) ? s1_ctr : filt;
            else
                bus.out_data <= '0;
        end
    end
endmodule

// File: tb/tb_gauss3x3_stream.sv
// Directed/random frames on Gaussian and bypass instances, checked against a 2-D array model.
module tb_gauss3x3_stream;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic sof = 1'b0;
    logic [DW-1:0] dat = '0;

    always #5 clk = ~clk;

    gauss3x3_stream_if #(.DATA_W(DW)) b0 ();
    gauss3x3_stream_if #(.DATA_W(DW)) b1 ();

    assign b0.in_valid = vld;
    assign b0.in_sof   = sof;
    assign b0.in_data  = dat;
    assign b1.in_valid = vld;
    assign b1.in_sof   = sof;
    assign b1.in_data  = dat;

    gauss3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    gauss3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        int cyc;
        int dat;
        bit sof;
        bit eol;
        bit done;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    rec_t mr;
    int   beat_q[$];
    int   cyc = 0;
    int   done_total = 0;
    int   rdy_low = 0;
    int   tests = 0;
    int   fails = 0;
    int   img [H][W];
    int   saved [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are logged before a new sof clears the logs, so only later cycles belong to the new frame.
    always @(negedge clk) begin
        if (b0.out_valid) begin
            mr.cyc = cyc; mr.dat = int'(b0.out_data); mr.sof = b0.out_sof;
            mr.eol = b0.out_eol; mr.done = b0.frame_done;
            q0.push_back(mr);
        end
        if (b1.out_valid) begin
            mr.cyc = cyc; mr.dat = int'(b1.out_data); mr.sof = b1.out_sof;
            mr.eol = b1.out_eol; mr.done = b1.frame_done;
            q1.push_back(mr);
        end
        if (b0.frame_done) done_total++;
        if (!b0.in_ready) rdy_low++;
        if (vld && b0.in_ready) begin
            if (sof) begin
                q0.delete(); q1.delete(); beat_q.delete(); rdy_low = 0;
            end
            beat_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int mode, input int k);
        int r = k / W;
        int c = k % W;
        int s = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        if (mode == 1) return img[r][c];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[r + dr][c + dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
        s = (s + 8) / 16;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int got0(input int k);
        return (k < q0.size()) ? q0[k].dat : -1;
    endfunction

    task automatic send_pix(input int d, input bit s, input int gap);
        bit sent = 1'b0;
        int g = 0;
        while (!sent && g < 1000) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                vld = 1'b0; sof = 1'b0;
            end else begin
                vld = 1'b1; sof = s; dat = DW'(d);
            end
            sent = vld && b0.in_ready;
            @(posedge clk); #1;
            g++;
        end
        vld = 1'b0; sof = 1'b0;
        if (!sent) check("send_timeout", int'(sent), 1);
    endtask

    task automatic send_frame(input int npix, input int gap);
        for (int i = 0; i < npix; i++) send_pix(img[i / W][i % W], i == 0, gap);
    endtask

    task automatic finish_frame();
        int g = 0;
        while (b0.busy && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        check("flush_timeout", int'(b0.busy), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int flag_bad = 0;
        int lat_bad = 0;
        check({tag, "_cnt0"}, q0.size(), N);
        check({tag, "_cnt1"}, q1.size(), N);
        check({tag, "_beats"}, beat_q.size(), N);
        check({tag, "_rdy_low"}, rdy_low, W + 1);
        if (q0.size() > 0 && beat_q.size() > W + 1)
            check({tag, "_first_lat"}, q0[0].cyc - beat_q[W + 1], 2);
        for (int k = 0; k < N && k < q0.size(); k++) begin
            check($sformatf("%s_m0_px%0d", tag, k), q0[k].dat, model(0, k));
            if (q0[k].sof != (k == 0) || q0[k].eol != (k % W == W - 1) || q0[k].done != (k == N - 1))
                flag_bad++;
            if (k + W + 1 < beat_q.size() && q0[k].cyc != beat_q[k + W + 1] + 2) lat_bad++;
            if (k < q1.size() && q1[k].cyc != q0[k].cyc) lat_bad++;
        end
        for (int k = 0; k < N && k < q1.size(); k++)
            check($sformatf("%s_m1_px%0d", tag, k), q1[k].dat, model(1, k));
        check({tag, "_flags"}, flag_bad, 0);
        check({tag, "_latency"}, lat_bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, int'(b0.out_valid), 0);
        check({tag, "_out_data"}, int'(b0.out_data), 0);
        check({tag, "_out_sof"}, int'(b0.out_sof), 0);
        check({tag, "_out_eol"}, int'(b0.out_eol), 0);
        check({tag, "_frame_done"}, int'(b0.frame_done), 0);
        check({tag, "_busy"}, int'(b0.busy), 0);
        check({tag, "_in_ready"}, int'(b0.in_ready), 1);
        check({tag, "_m1_out_valid"}, int'(b1.out_valid), 0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
    endtask

    initial begin
        int d;
        int bad;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        d = done_total;
        send_frame(N, 0); finish_frame();
        check_frame("flat");
        check("flat_done", done_total - d, 1);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
        img[2][3] = 160;
        send_frame(N, 0); finish_frame();
        check_frame("impulse");
        check("imp_centre", got0(2 * W + 3), 40);
        check("imp_up",     got0(1 * W + 3), 20);
        check("imp_down",   got0(3 * W + 3), 20);
        check("imp_left",   got0(2 * W + 2), 20);
        check("imp_right",  got0(2 * W + 4), 20);
        check("imp_diag_ul", got0(1 * W + 2), 10);
        check("imp_diag_ur", got0(1 * W + 4), 10);
        check("imp_diag_dl", got0(3 * W + 2), 10);
        check("imp_diag_dr", got0(3 * W + 4), 10);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
        send_frame(N, 0); finish_frame();
        check_frame("max");
        check("max_interior", got0(W + 1), 255);

        fill_random();
        send_frame(N, 0); finish_frame();
        check_frame("rand_cont");
        for (int k = 0; k < N; k++) saved[k] = got0(k);
        send_frame(N, 30); finish_frame();
        check_frame("rand_gaps");
        bad = 0;
        for (int k = 0; k < N; k++) if (got0(k) != saved[k]) bad++;
        check("gaps_vs_cont", bad, 0);

        for (int k = 0; k < N; k++) img[k / W][k % W] = k;
        send_frame(N, 0); finish_frame();
        check_frame("ramp");

        d = done_total;
        fill_random();
        send_frame(20, 0);
        fill_random();
        send_frame(N, 0); finish_frame();
        check_frame("restart");
        check("restart_done", done_total - d, 1);

        d = done_total;
        fill_random();
        send_frame(30, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_total - d, 0);
        check("mid_rst_idle", int'(b0.busy), 0);
        fill_random();
        send_frame(N, 0); finish_frame();
        check_frame("post_rst");
        check("post_rst_done", done_total - d, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
